// File: rtl/multi_channel_timer_pwm.sv
// N-channel timer/PWM: shared prescaled counter, normal/fast/phase-correct modes, double-buffered TOP/compare.
// Optional output polarity inversion is enabled by defining PWM_POLARITY_EN.
module multi_channel_timer_pwm #(
    parameter int WIDTH   = 32,
    parameter int NCH     = 2,
    parameter int PRESC_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           tmr_src,
    input  logic [1:0]           tmr_mode,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic [WIDTH-1:0]     timer_top,
    input  logic [NCH*WIDTH-1:0] pwm_cmp,
`ifdef PWM_POLARITY_EN
    input  logic [NCH-1:0]       pwm_pol,
`endif
    input  logic                 irq_clr,
    output logic [WIDTH-1:0]     count,
    output logic                 count_dir,
    output logic [NCH-1:0]       pwm_out,
    output logic [NCH-1:0]       cmp_match,
    output logic                 timer_interrupt
);

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'b00,
        MODE_FAST    = 2'b01,
        MODE_PHASE   = 2'b10,
        MODE_NORMAL2 = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    mode_e              mode_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH-1:0]   top_sh;
    logic [WIDTH-1:0]   cmp_sh  [NCH];
    logic [WIDTH-1:0]   cmp_eff [NCH];
    logic [NCH-1:0]     pwm_reg;

    logic               tick;
    logic [PRESC_W-1:0] presc_next;
    logic               running;
    logic               mode_chg;
    logic               is_phase;
    logic               is_fast;
    logic [WIDTH-1:0]   cnt_next;
    logic               dir_next;
    logic               period_end;
    logic               update;
    logic               load_sh;
    logic [NCH-1:0]     pwm_next;
    logic [NCH-1:0]     match_next;

    assign running  = tmr_src[0] ^ tmr_src[1];
    assign mode_chg = (mode_e'(tmr_mode) != mode_q);
    assign is_phase = (mode_q == MODE_PHASE);
    assign is_fast  = (mode_q == MODE_FAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tick       = 1'b0;
        presc_next = '0;
        case (tmr_src)
            2'b01: tick = 1'b1;
            2'b10: begin
                tick       = (presc_cnt == prescale);
                presc_next = tick ? '0 : presc_cnt + PRESC_ONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_next   = count;
        dir_next   = 1'b0;
        period_end = 1'b0;
        if (is_phase) begin
            if (top_sh == '0) begin
                cnt_next   = '0;
                period_end = 1'b1;
            end else if (!count_dir) begin
                cnt_next = count + CNT_ONE;
                dir_next = (cnt_next >= top_sh);
            end else begin
                cnt_next = count - CNT_ONE;
                dir_next = 1'b1;
                if (cnt_next == '0) begin
                    dir_next   = 1'b0;
                    period_end = 1'b1;
                end
            end
        end else if (count >= top_sh) begin
            cnt_next   = '0;
            period_end = 1'b1;
        end else begin
            cnt_next = count + CNT_ONE;
        end
    end

    // Shadows reload while stopped, on a mode change, and at the period boundary.
    assign update  = tick & period_end;
    assign load_sh = ~running | mode_chg | update;

    // The period that starts on an update edge is evaluated against the freshly loaded compares.
    always_comb begin
        pwm_next   = pwm_reg;
        match_next = '0;
        for (int k = 0; k < NCH; k++) begin
            cmp_eff[k]    = load_sh ? pwm_cmp[k*WIDTH +: WIDTH] : cmp_sh[k];
            match_next[k] = (cnt_next == cmp_eff[k]);
            if (is_fast || is_phase)
                pwm_next[k] = (cnt_next < cmp_eff[k]);
            else
                pwm_next[k] = pwm_reg[k] ^ match_next[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q          <= MODE_NORMAL;
            presc_cnt       <= '0;
            count           <= '0;
            count_dir       <= 1'b0;
            pwm_reg         <= '0;
            cmp_match       <= '0;
            timer_interrupt <= 1'b0;
            top_sh          <= '0;
            // NOTE: the compare shadow array is small and must read 0 after reset, so it is reset too.
            cmp_sh          <= '{default: '0};
        end else begin
            mode_q <= mode_e'(tmr_mode);
            if (load_sh) begin
                top_sh <= timer_top;
                for (int k = 0; k < NCH; k++)
                    cmp_sh[k] <= pwm_cmp[k*WIDTH +: WIDTH];
            end
            if (mode_chg) begin
                presc_cnt       <= '0;
                count           <= '0;
                count_dir       <= 1'b0;
                pwm_reg         <= '0;
                cmp_match       <= '0;
                timer_interrupt <= timer_interrupt & ~irq_clr;
            end else begin
                presc_cnt       <= presc_next;
                cmp_match       <= tick ? match_next : '0;
                timer_interrupt <= update | (timer_interrupt & ~irq_clr);
                if (tick) begin
                    count     <= cnt_next;
                    count_dir <= dir_next;
                    pwm_reg   <= pwm_next;
                end
            end
        end
    end

`ifdef PWM_POLARITY_EN
    assign pwm_out = pwm_reg ^ pwm_pol;
`else
    assign pwm_out = pwm_reg;
`endif

endmodule

// File: tb/tb_multi_channel_timer_pwm.sv
// Directed bench for multi_channel_timer_pwm (default build, two channels, 32-bit counter).
module tb_multi_channel_timer_pwm;

    localparam int WIDTH   = 32;
    localparam int NCH     = 2;
    localparam int PRESC_W = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [1:0]           tmr_src = 2'b00;
    logic [1:0]           tmr_mode = 2'b00;
    logic [PRESC_W-1:0]   prescale = '0;
    logic [WIDTH-1:0]     timer_top = '0;
    logic [NCH*WIDTH-1:0] pwm_cmp = '0;
    logic                 irq_clr = 1'b0;
    logic [WIDTH-1:0]     count;
    logic                 count_dir;
    logic [NCH-1:0]       pwm_out;
    logic [NCH-1:0]       cmp_match;
    logic                 timer_interrupt;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned pc_cnt [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int unsigned pc_dir [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int unsigned pc_pwm [8] = '{1, 0, 0, 0, 0, 0, 1, 1};

    multi_channel_timer_pwm #(.WIDTH(WIDTH), .NCH(NCH), .PRESC_W(PRESC_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .tmr_src         (tmr_src),
        .tmr_mode        (tmr_mode),
        .prescale        (prescale),
        .timer_top       (timer_top),
        .pwm_cmp         (pwm_cmp),
        .irq_clr         (irq_clr),
        .count           (count),
        .count_dir       (count_dir),
        .pwm_out         (pwm_out),
        .cmp_match       (cmp_match),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #22;
        check("rst count", count, 0);
        check("rst dir", {31'd0, count_dir}, 0);
        check("rst pwm", {30'd0, pwm_out}, 0);
        check("rst match", {30'd0, cmp_match}, 0);
        check("rst irq", {31'd0, timer_interrupt}, 0);
        reset = 1'b1;

        // Fast PWM, top=9, cmp0=3, cmp1=0
        tmr_mode  = 2'b01;
        timer_top = 32'd9;
        pwm_cmp   = {32'd0, 32'd3};
        step();
        step();
        check("fast setup count", count, 0);
        tmr_src = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("fast cnt %0d", i), count, i % 10);
            check($sformatf("fast pwm0 %0d", i), {31'd0, pwm_out[0]}, ((i % 10) < 3) ? 1 : 0);
            check($sformatf("fast pwm1 %0d", i), {31'd0, pwm_out[1]}, 0);
            check($sformatf("fast irq %0d", i), {31'd0, timer_interrupt}, (i >= 10) ? 1 : 0);
        end

        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("fast irq cleared", {31'd0, timer_interrupt}, 0);
        check("fast cnt after clr", count, 1);

        // Compare 3 -> 7 written at count=5: takes effect only after the wrap
        for (int j = 1; j <= 19; j++) begin
            step();
            check($sformatf("buf cnt %0d", j), count, (1 + j) % 10);
            if (j < 9)
                check($sformatf("buf pwm0 %0d", j), {31'd0, pwm_out[0]}, (((1 + j) % 10) < 3) ? 1 : 0);
            else
                check($sformatf("buf pwm0 %0d", j), {31'd0, pwm_out[0]}, (((1 + j) % 10) < 7) ? 1 : 0);
            if (j == 4) pwm_cmp = {32'd0, 32'd7};
        end

        // irq_clr coinciding with overflow keeps the flag; a lone clear drops it
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("irq lone clr a", {31'd0, timer_interrupt}, 0);
        repeat (8) step();
        check("irq pre-wrap count", count, 9);
        irq_clr = 1'b1;
        step();
        check("irq set+clr count", count, 0);
        check("irq set+clr", {31'd0, timer_interrupt}, 1);
        step();
        irq_clr = 1'b0;
        check("irq lone clr b", {31'd0, timer_interrupt}, 0);

        // Phase-correct, top=4, cmp0=2
        tmr_src   = 2'b00;
        tmr_mode  = 2'b10;
        timer_top = 32'd4;
        pwm_cmp   = {32'd0, 32'd2};
        step();
        check("pc setup count", count, 0);
        check("pc setup dir", {31'd0, count_dir}, 0);
        tmr_src = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("pc cnt %0d", i), count, pc_cnt[(i - 1) % 8]);
            check($sformatf("pc dir %0d", i), {31'd0, count_dir}, pc_dir[(i - 1) % 8]);
            check($sformatf("pc pwm0 %0d", i), {31'd0, pwm_out[0]}, pc_pwm[(i - 1) % 8]);
            check($sformatf("pc irq %0d", i), {31'd0, timer_interrupt}, (i >= 8) ? 1 : 0);
        end

        // Normal, src=10, prescale=3, top=5, cmp0=2
        tmr_src   = 2'b00;
        tmr_mode  = 2'b00;
        timer_top = 32'd5;
        pwm_cmp   = {32'd0, 32'd2};
        prescale  = 8'd3;
        irq_clr   = 1'b1;
        step();
        irq_clr = 1'b0;
        check("nrm setup irq", {31'd0, timer_interrupt}, 0);
        check("nrm setup pwm", {30'd0, pwm_out}, 0);
        step();
        tmr_src = 2'b10;
        for (int n = 1; n <= 48; n++) begin
            step();
            check($sformatf("nrm cnt %0d", n), count, (n / 4) % 6);
            check($sformatf("nrm match0 %0d", n), {31'd0, cmp_match[0]}, ((n % 24) == 8) ? 1 : 0);
            check($sformatf("nrm pwm0 %0d", n), {31'd0, pwm_out[0]}, (n >= 8 && n < 32) ? 1 : 0);
            check($sformatf("nrm irq %0d", n), {31'd0, timer_interrupt}, (n >= 24) ? 1 : 0);
        end

        // Asynchronous reset mid-count with no clock edge
        tmr_src   = 2'b00;
        tmr_mode  = 2'b01;
        timer_top = 32'd9;
        pwm_cmp   = {32'd0, 32'd9};
        step();
        tmr_src = 2'b01;
        repeat (7) step();
        check("arst pre count", count, 7);
        check("arst pre pwm0", {31'd0, pwm_out[0]}, 1);
        check("arst pre irq", {31'd0, timer_interrupt}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst count", count, 0);
        check("arst pwm", {30'd0, pwm_out}, 0);
        check("arst irq", {31'd0, timer_interrupt}, 0);
        check("arst dir", {31'd0, count_dir}, 0);
        #20;
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
